xadc_temp_reader: RTL and testbench
===================================

Name: xadc_temp_reader

Overview:
- Polls the on-chip XADC temperature channel over the DRP read interface at a fixed interval.
- Converts each 12-bit raw code to integer °C, clamped to 0..199.
- Presents the result as temp_c, the producer side of the temp_c bus consumed by the seven-segment display driver.
- Sits between the XADC primitive and the display logic, in the 100 MHz clk domain.

Parameters:
- POLL_CYCLES, 100000, clk cycles from one DRP request (den) to the next (1 ms at 100 MHz); minimum 16.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for drdy after den before abandoning the read.
- TEMP_ADDR, 7'h00, DRP address of the XADC temperature status register.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  asynchronous, active-high reset
- drp_den  output  1  DRP enable, single-cycle pulse per read
- drp_daddr  output  7  DRP address; TEMP_ADDR whenever drp_den=1, else 0
- drp_dwe  output  1  DRP write enable; constant 0
- drp_di  output  16  DRP write data; constant 0
- drp_drdy  input  1  DRP read-data-valid strobe from XADC
- drp_do  input  16  DRP read data; raw code in bits [15:4]
- temp_raw  output  12  last captured raw code
- temp_c  output  8  last converted temperature, integer °C, 0..199
- temp_valid  output  1  one-cycle pulse when temp_c/temp_raw update
- drp_err  output  1  sticky flag, set on any drdy timeout

Behaviour:
Reset (async, rst=1):
- All outputs 0.
- FSM in REQ; period and timeout counters 0.
- rst asserted mid-transaction abandons the transaction. No temp_valid pulse is emitted. Any later drdy belonging to the abandoned read is ignored because FSM is not in WAIT_RDY.

FSM states: REQ, WAIT_RDY, CONV, UPDATE, IDLE.
- REQ: drp_den=1 and drp_daddr=TEMP_ADDR for exactly one cycle. Period counter cleared to 0. Timeout counter cleared. Next state WAIT_RDY.
- WAIT_RDY: on drp_drdy=1, capture drp_do[15:4] into an internal raw register; next state CONV. Otherwise increment timeout counter. When it reaches TIMEOUT_CYCLES-1 without drdy, set drp_err, keep temp_c/temp_raw, go to IDLE.
- CONV: register tmp = (raw * 504) >> 12. The product is 21 bits unsigned; tmp is 9 bits, range 0..503. Next state UPDATE.
- UPDATE: latch temp_c and temp_raw, pulse temp_valid=1 for this cycle only; next state IDLE. temp_c is:
  - 0 if tmp < 273
  - 199 if tmp - 273 > 199
  - tmp - 273 otherwise
- IDLE: wait until period counter = POLL_CYCLES-1, then go to REQ.

Period counter:
- Increments every cycle in all states except REQ; it is cleared in REQ.
- Hence den-to-den spacing is exactly POLL_CYCLES cycles when the transaction finishes in time. If a transaction outlasts POLL_CYCLES, REQ follows immediately after IDLE is entered.

Timing and data rules:
- Latency: drdy sampled high at edge N; temp_c and temp_valid updated at edge N+2 (CONV then UPDATE).
- First request is issued in the first cycle after rst deasserts.
- drp_drdy outside WAIT_RDY is ignored; drp_do is sampled only with drdy in WAIT_RDY.
- drp_do[3:0] are ignored.
- drp_err clears only on reset. After a timeout, polling continues normally; a later successful read updates temp_c but does not clear drp_err.
- Only one outstanding DRP read at any time; den is never asserted while in WAIT_RDY.

Test Plan:
- Reset release, drdy 3 cycles after den with drp_do=16'h9770 (code 0x977) -> drp_den pulse first cycle after reset, daddr=7'h00, temp_raw=12'h977, temp_c=25, temp_valid one cycle exactly 2 cycles after drdy.
- drp_do=16'hA930 (code 0xA93) -> temp_c=60. drp_do=16'h0000 -> temp_c=0 (low clamp). drp_do=16'hFFF0 -> temp_c=199 (high clamp, tmp=503).
- Set POLL_CYCLES=64; run 4 reads with drdy latency 5 -> den pulses spaced exactly 64 cycles, one temp_valid per read, drp_dwe=0 and drp_di=0 throughout.
- Set TIMEOUT_CYCLES=8 and never assert drdy -> drp_err rises 8 cycles after den, temp_c holds prior value (25), no temp_valid. Next read succeeds with code 0xA93 -> temp_c=60, drp_err stays 1.
- Spurious drdy asserted while in IDLE with drp_do=16'hFFF0 -> no change to temp_c/temp_raw, no temp_valid.
- Assert rst one cycle after den, then assert drdy during reset -> all outputs 0. After release, a fresh den is issued first cycle, and only its drdy produces temp_valid.

Source files
------------

// File: rtl/xadc_temp_reader.sv
// xadc_temp_reader
// Polls the XADC on-chip temperature channel through the DRP read port at a
// fixed interval. Each 12-bit raw code becomes an integer degree Celsius value
// clamped to 0..199. That value drives temp_c for the seven-segment display
// driver. Everything runs in the 100 MHz clk domain.

module xadc_temp_reader #(
  parameter int unsigned POLL_CYCLES    = 100000,  // den-to-den spacing, >= 16
  parameter int unsigned TIMEOUT_CYCLES = 255,     // max wait for drdy after den
  parameter logic [6:0]  TEMP_ADDR      = 7'h00    // XADC temperature status register
) (
  input  logic        clk,
  input  logic        rst,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic [11:0] temp_raw,
  output logic [7:0]  temp_c,
  output logic        temp_valid,
  output logic        drp_err
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT_RDY,
    S_CONV,
    S_UPDATE,
    S_IDLE
  } state_t;

  state_t      r_state;
  logic [31:0] r_period;   // cycles since the last den, cleared in REQ
  logic [31:0] r_tmo;      // cycles spent waiting for drdy
  logic [11:0] r_raw;      // code captured with drdy, not yet published
  logic [8:0]  r_tmp;      // (raw * 504) >> 12, range 0..503

  logic [8:0]  w_tmp;
  logic [8:0]  w_excess;
  logic [7:0]  w_temp_c;

  // The DRP port is read-only here.
  assign drp_dwe = 1'b0;
  assign drp_di  = 16'h0000;

  // den is a decode of the REQ state. This lets the first request appear in
  // the very first cycle after reset releases. The decode is masked while rst
  // is held so every output reads 0 during reset.
  assign drp_den   = (r_state == S_REQ) && !rst;
  assign drp_daddr = drp_den ? TEMP_ADDR : 7'h00;

  // Scaling: 504/4096 of the 12-bit code gives Kelvin. The product fits in 21 bits.
  assign w_tmp    = 9'((21'(r_raw) * 21'd504) >> 12);
  assign w_excess = r_tmp - 9'd273;

  // Convert Kelvin to Celsius and clamp to the display range 0..199.
  always_comb begin
    w_temp_c = 8'd0;
    if (r_tmp < 9'd273) begin
      w_temp_c = 8'd0;
    end else if (w_excess > 9'd199) begin
      w_temp_c = 8'd199;
    end else begin
      w_temp_c = w_excess[7:0];
    end
  end

  // Poll sequencer: request, wait for drdy or timeout, convert, publish, idle.
  // NOTE: every register in this block is updated with <=, so reads within
  // the same edge see the previous value. Each branch depends on that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_period   <= '0;
      r_tmo      <= '0;
      r_raw      <= '0;
      r_tmp      <= '0;
      temp_raw   <= '0;
      temp_c     <= '0;
      temp_valid <= 1'b0;
      drp_err    <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      r_period   <= (r_state == S_REQ) ? 32'd0 : r_period + 32'd1;

      case (r_state)
        S_REQ: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_RDY;
        end

        S_WAIT_RDY: begin
          if (drp_drdy) begin
            // The low nibble of drp_do is dropped by the shift.
            r_raw   <= 12'(drp_do >> 4);
            r_state <= S_CONV;
          end else if (r_tmo == 32'(TIMEOUT_CYCLES - 1)) begin
            drp_err <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end

        S_CONV: begin
          r_tmp   <= w_tmp;
          r_state <= S_UPDATE;
        end

        S_UPDATE: begin
          temp_c     <= w_temp_c;
          temp_raw   <= r_raw;
          temp_valid <= 1'b1;
          r_state    <= S_IDLE;
        end

        S_IDLE: begin
          // The counter reads 0 in the cycle after den. Leaving at POLL-2
          // makes the next REQ cycle the one whose count would be POLL-1,
          // so dens sit exactly POLL_CYCLES apart. If a read overran the
          // interval, the >= sends the FSM straight back to REQ.
          if (r_period >= 32'(POLL_CYCLES - 2)) begin
            r_state <= S_REQ;
          end
        end

        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_temp_reader.sv
// Directed bench for xadc_temp_reader: conversion points, clamps, den spacing,
// drdy timeout, a spurious drdy and reset during a transaction.

module tb_xadc_temp_reader;

  logic        clk;
  logic        rst;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [11:0] temp_raw;
  logic [7:0]  temp_c;
  logic        temp_valid;
  logic        drp_err;

  int n_cmp      = 0;
  int n_bad      = 0;
  int cyc        = 0;
  int valid_cnt  = 0;
  int bad_static = 0;
  int den_cyc    = 0;
  int prev_cyc   = 0;

  xadc_temp_reader #(
    .POLL_CYCLES    (64),
    .TIMEOUT_CYCLES (8),
    .TEMP_ADDR      (7'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .drp_den    (drp_den),
    .drp_daddr  (drp_daddr),
    .drp_dwe    (drp_dwe),
    .drp_di     (drp_di),
    .drp_drdy   (drp_drdy),
    .drp_do     (drp_do),
    .temp_raw   (temp_raw),
    .temp_c     (temp_c),
    .temp_valid (temp_valid),
    .drp_err    (drp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Background monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (temp_valid === 1'b1) valid_cnt++;
    if (drp_dwe !== 1'b0 || drp_di !== 16'h0000) bad_static++;
    if (drp_den !== 1'b1 && drp_daddr !== 7'h00) bad_static++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the next den, bounded. Records the cycle at which it was seen.
  task automatic wait_den(input string tag);
    int n;
    n = 0;
    while (drp_den !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (drp_den !== 1'b1) check({tag, " den never came"}, 32'(drp_den), 32'd1);
    prev_cyc = den_cyc;
    den_cyc  = cyc;
  endtask

  // One complete read: den, drdy after lat cycles, then the result 2 edges later.
  task automatic do_read(input string tag, input int lat, input logic [15:0] dout,
                         input logic [11:0] exp_raw, input logic [7:0] exp_c);
    wait_den(tag);
    check({tag, " daddr"}, 32'(drp_daddr), 32'h00);
    repeat (lat) @(negedge clk);
    drp_drdy = 1'b1;
    drp_do   = dout;
    @(negedge clk);                       // drdy sampled at edge N
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;
    check({tag, " valid@N"}, 32'(temp_valid), 32'd0);
    @(negedge clk);                       // after edge N+1
    check({tag, " valid@N+1"}, 32'(temp_valid), 32'd0);
    @(negedge clk);                       // after edge N+2
    check({tag, " valid@N+2"}, 32'(temp_valid), 32'd1);
    check({tag, " temp_raw"}, 32'(temp_raw), 32'(exp_raw));
    check({tag, " temp_c"}, 32'(temp_c), 32'(exp_c));
    @(negedge clk);
    check({tag, " valid@N+3"}, 32'(temp_valid), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;

    repeat (3) @(negedge clk);
    check("reset outputs", 32'({drp_den, drp_daddr, temp_raw, temp_c, temp_valid, drp_err}), 32'd0);
    rst = 1'b0;
    #1;
    check("den first cycle", 32'(drp_den), 32'd1);

    // Conversion points and clamps. Every read after the first checks the 64-cycle spacing.
    do_read("r0 25C",   3, 16'h9770, 12'h977, 8'd25);
    do_read("r1 60C",   5, 16'hA930, 12'hA93, 8'd60);
    check("r1 spacing", 32'(den_cyc - prev_cyc), 32'd64);
    do_read("r2 low",   5, 16'h0000, 12'h000, 8'd0);
    check("r2 spacing", 32'(den_cyc - prev_cyc), 32'd64);
    do_read("r3 high",  5, 16'hFFF0, 12'hFFF, 8'd199);
    check("r3 spacing", 32'(den_cyc - prev_cyc), 32'd64);
    do_read("r4 1C",    5, 16'h8B30, 12'h8B3, 8'd1);
    check("r4 spacing", 32'(den_cyc - prev_cyc), 32'd64);
    do_read("r5 198C",  5, 16'hEF40, 12'hEF4, 8'd198);
    do_read("r6 nibble", 3, 16'h977F, 12'h977, 8'd25);
    check("valid count r6", 32'(valid_cnt), 32'd7);

    // A spurious drdy in IDLE must be ignored.
    repeat (5) @(negedge clk);
    drp_drdy = 1'b1;
    drp_do   = 16'hFFF0;
    repeat (3) @(negedge clk);
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;
    repeat (2) @(negedge clk);
    check("spurious temp_c", 32'(temp_c), 32'd25);
    check("spurious temp_raw", 32'(temp_raw), 32'h977);
    check("spurious valid count", 32'(valid_cnt), 32'd7);

    // Timeout: no drdy. drp_err rises at the 8th edge after the den edge.
    wait_den("tmo");
    check("tmo spacing", 32'(den_cyc - prev_cyc), 32'd64);
    repeat (8) @(posedge clk);
    #1;
    check("tmo err early", 32'(drp_err), 32'd0);
    @(posedge clk);
    #1;
    check("tmo err set", 32'(drp_err), 32'd1);
    check("tmo temp_c held", 32'(temp_c), 32'd25);
    repeat (4) @(negedge clk);
    check("tmo no valid", 32'(valid_cnt), 32'd7);

    do_read("r7 after tmo", 3, 16'hA930, 12'hA93, 8'd60);
    check("r7 spacing", 32'(den_cyc - prev_cyc), 32'd64);
    check("r7 err sticky", 32'(drp_err), 32'd1);

    // Reset one cycle after den. The stale drdy arrives during reset.
    wait_den("r8");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst outputs", 32'({drp_den, drp_daddr, temp_raw, temp_c, temp_valid, drp_err}), 32'd0);
    drp_drdy = 1'b1;
    drp_do   = 16'h9770;
    @(negedge clk);
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;
    @(negedge clk);
    check("midrst no valid", 32'(valid_cnt), 32'd8);
    rst = 1'b0;
    #1;
    check("midrst den first cycle", 32'(drp_den), 32'd1);
    do_read("r9 after rst", 3, 16'hA930, 12'hA93, 8'd60);
    check("r9 err cleared", 32'(drp_err), 32'd0);
    check("total valid count", 32'(valid_cnt), 32'd9);
    check("dwe/di/daddr idle", 32'(bad_static), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
